// File: rtl/triangle_cull_pkg.sv
// Shared types and clip-space bounds for the triangle cull stage.
// The `XMIN..`ZMAX macros are the single source of the bounds for RTL and benches alike.
`ifndef CLIP_DEFINES_SV
`define CLIP_DEFINES_SV
`define XMIN (-16'sd2048)
`define XMAX (16'sd2047)
`define YMIN (-16'sd1536)
`define YMAX (16'sd1535)
`define ZMIN (16'sd0)
`define ZMAX (16'sd8191)
`endif

package triangle_cull_pkg;

   typedef struct packed {
      shortint x;
      shortint y;
      shortint z;
   } Point3D;

   typedef struct packed {
      Point3D p;
      Point3D q;
      Point3D r;
   } Triangle3D;

   typedef enum logic [1:0] {IDLE, CHECK, SEND} cull_state_t;

   // Index 0/1/2 = x/y/z, matching the axis order inside Point3D.
   localparam logic signed [15:0] AXIS_MIN [3] = '{`XMIN, `YMIN, `ZMIN};
   localparam logic signed [15:0] AXIS_MAX [3] = '{`XMAX, `YMAX, `ZMAX};

endpackage

// File: rtl/triangle_cull_vertex_bounds.sv
// Tests one vertex against the inclusive per-axis clip bounds (signed 16-bit compares).
// With TRI_CULL_CLAMP_EN it also returns the vertex clamped into those bounds.
module triangle_cull_vertex_bounds
   import triangle_cull_pkg::*;
(
   input  Point3D vtx_i,
`ifdef TRI_CULL_CLAMP_EN
   output Point3D clamped_o,
`endif
   output logic   oob_o
);

   logic signed [15:0] coord [3];
   logic [2:0]         axis_oob;

   assign coord[0] = vtx_i.x;
   assign coord[1] = vtx_i.y;
   assign coord[2] = vtx_i.z;

`ifdef TRI_CULL_CLAMP_EN
   logic signed [15:0] clamp_c [3];
`endif

   for (genvar gi = 0; gi < 3; gi++) begin : g_axis
      logic lo_hit;
      logic hi_hit;
      assign lo_hit       = coord[gi] < AXIS_MIN[gi];
      assign hi_hit       = coord[gi] > AXIS_MAX[gi];
      assign axis_oob[gi] = lo_hit | hi_hit;
`ifdef TRI_CULL_CLAMP_EN
      assign clamp_c[gi]  = lo_hit ? AXIS_MIN[gi] : (hi_hit ? AXIS_MAX[gi] : coord[gi]);
`endif
   end

`ifdef TRI_CULL_CLAMP_EN
   assign clamped_o = '{x: clamp_c[0], y: clamp_c[1], z: clamp_c[2]};
`endif

   assign oob_o = |axis_oob;

endmodule

// File: rtl/triangle_cull.sv
// Triangle cull stage: checks one vertex per cycle against the clip bounds, then forwards or drops.
// Build option TRI_CULL_CLAMP_EN: clamp out-of-bounds coords and forward instead of dropping.
module triangle_cull
   import triangle_cull_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  Triangle3D        tri_in,
   output logic             out_valid,
   input  logic             out_ready,
   output Triangle3D        tri_out,
   output logic [CNT_W-1:0] cull_count,
`ifdef TRI_CULL_CLAMP_EN
   output logic             out_clamped,
`endif
   output logic             busy
);

   cull_state_t      state_q;
   Triangle3D        tri_q;
   logic [1:0]       vtx_q;
   logic             oob_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [CNT_W-1:0] cnt_q;

   Point3D           cur_vtx;
   logic             vtx_oob;
   logic             oob_d;
   logic             last_vtx;
   logic [CNT_W-1:0] cnt_d;

`ifdef TRI_CULL_CLAMP_EN
   Point3D           clamped_vtx;
   logic             out_clamped_q;
`endif

   always_comb begin
      cur_vtx = tri_q.r;
      case (vtx_q)
         2'd0:    cur_vtx = tri_q.p;
         2'd1:    cur_vtx = tri_q.q;
         default: cur_vtx = tri_q.r;
      endcase
   end

   triangle_cull_vertex_bounds u_bounds (
      .vtx_i     (cur_vtx),
`ifdef TRI_CULL_CLAMP_EN
      .clamped_o (clamped_vtx),
`endif
      .oob_o     (vtx_oob)
   );

   assign oob_d    = oob_q | vtx_oob;
   assign last_vtx = (vtx_q == 2'd2);
   assign cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         tri_q         <= '0;
         vtx_q         <= 2'd0;
         oob_q         <= 1'b0;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         cnt_q         <= '0;
`ifdef TRI_CULL_CLAMP_EN
         out_clamped_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  tri_q      <= tri_in;
                  vtx_q      <= 2'd0;
                  oob_q      <= 1'b0;
                  in_ready_q <= 1'b0;
                  state_q    <= CHECK;
               end
            end
            CHECK: begin
               oob_q <= oob_d;
               vtx_q <= vtx_q + 2'd1;
`ifdef TRI_CULL_CLAMP_EN
               case (vtx_q)
                  2'd0:    tri_q.p <= clamped_vtx;
                  2'd1:    tri_q.q <= clamped_vtx;
                  default: tri_q.r <= clamped_vtx;
               endcase
               if (last_vtx) begin
                  out_clamped_q <= oob_d;
                  out_valid_q   <= 1'b1;
                  state_q       <= SEND;
                  if (oob_d) cnt_q <= cnt_d;
               end
`else
               if (last_vtx) begin
                  if (oob_d) begin
                     cnt_q      <= cnt_d;
                     in_ready_q <= 1'b1;
                     state_q    <= IDLE;
                  end else begin
                     out_valid_q <= 1'b1;
                     state_q     <= SEND;
                  end
               end
`endif
            end
            SEND: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign tri_out    = tri_q;
   assign cull_count = cnt_q;
   assign busy       = (state_q != IDLE);
`ifdef TRI_CULL_CLAMP_EN
   assign out_clamped = out_clamped_q;
`endif

endmodule

// File: tb/tb_triangle_cull.sv
// Bench for triangle_cull (CNT_W=4): vector table, randomized triangles against a bounds/clamp
// model, output stall, counter saturation and reset in the middle of CHECK.
module tb_triangle_cull;
   import triangle_cull_pkg::*;

   localparam int CW = 4;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   Triangle3D     tri_in;
   logic          out_valid;
   logic          out_ready;
   Triangle3D     tri_out;
   logic [CW-1:0] cull_count;
   logic          busy;
`ifdef TRI_CULL_CLAMP_EN
   logic          out_clamped;
   localparam bit CLAMP = 1'b1;
`else
   localparam bit CLAMP = 1'b0;
`endif

   int total;
   int bad;
   int model_cnt;
   int n_tri;

   triangle_cull #(.CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .tri_in     (tri_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .tri_out    (tri_out),
      .cull_count (cull_count),
`ifdef TRI_CULL_CLAMP_EN
      .out_clamped(out_clamped),
`endif
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: a triangle is out of bounds when any of its nine coordinates leaves [MIN,MAX] of its axis.
   function automatic bit model_oob(input Triangle3D t);
      int c  [9];
      int lo [3];
      int hi [3];
      lo = '{int'(`XMIN), int'(`YMIN), int'(`ZMIN)};
      hi = '{int'(`XMAX), int'(`YMAX), int'(`ZMAX)};
      c  = '{int'(t.p.x), int'(t.p.y), int'(t.p.z),
             int'(t.q.x), int'(t.q.y), int'(t.q.z),
             int'(t.r.x), int'(t.r.y), int'(t.r.z)};
      for (int k = 0; k < 9; k++)
         if (c[k] < lo[k % 3] || c[k] > hi[k % 3]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic shortint clampc(input shortint v, input shortint lo, input shortint hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic Point3D clamp_pt(input Point3D v);
      Point3D o;
      o.x = clampc(v.x, `XMIN, `XMAX);
      o.y = clampc(v.y, `YMIN, `YMAX);
      o.z = clampc(v.z, `ZMIN, `ZMAX);
      return o;
   endfunction

   function automatic Triangle3D model_clamp(input Triangle3D t);
      Triangle3D o;
      o.p = clamp_pt(t.p);
      o.q = clamp_pt(t.q);
      o.r = clamp_pt(t.r);
      return o;
   endfunction

   function automatic shortint rand_coord(input int lo, input int hi);
      if ($urandom_range(0, 9) != 0) return shortint'(lo + int'($urandom_range(0, hi - lo)));
      return shortint'($urandom);
   endfunction

   function automatic Point3D rand_pt();
      Point3D v;
      v.x = rand_coord(int'(`XMIN), int'(`XMAX));
      v.y = rand_coord(int'(`YMIN), int'(`YMAX));
      v.z = rand_coord(int'(`ZMIN), int'(`ZMAX));
      return v;
   endfunction

   // Runs one triangle through accept, three CHECK cycles, and either the drop or the SEND handshake.
   task automatic run_tri(input Triangle3D t, input int hold, input bit rdy_early);
      bit        oob;
      bit        fwd;
      Triangle3D exp_t;
      oob   = model_oob(t);
      fwd   = CLAMP || !oob;
      exp_t = CLAMP ? model_clamp(t) : t;
      n_tri++;
      check("idle_ready", {in_ready, busy, out_valid}, 3'b100);
      tri_in    = t;
      in_valid  = 1'b1;
      out_ready = rdy_early;
      tick();
      // cycle 1..3: busy, new requests ignored
      for (int c = 1; c <= 3; c++) begin
         check($sformatf("check_c%0d", c), {in_ready, busy, out_valid}, 3'b010);
         tri_in   = ~t;
         in_valid = (c < 3);
         tick();
      end
      in_valid = 1'b0;
      if (oob && model_cnt < (1 << CW) - 1) model_cnt++;
      check("count_c4", cull_count, model_cnt);
      if (!fwd) begin
         check("cull_c4", {in_ready, busy, out_valid}, 3'b100);
      end else begin
         check("send_c4", {in_ready, busy, out_valid}, 3'b011);
         check("tri_out", tri_out, exp_t);
`ifdef TRI_CULL_CLAMP_EN
         check("out_clamped", out_clamped, oob);
`endif
         if (!rdy_early) begin
            for (int h = 0; h < hold; h++) begin
               tick();
               check("stall_ctrl", {in_ready, out_valid}, 2'b01);
               check("stall_tri", tri_out, exp_t);
            end
            out_ready = 1'b1;
         end
         tick();
         out_ready = 1'b0;
         check("after_send", {in_ready, busy, out_valid}, 3'b100);
      end
      $display("tri %0d oob=%0d fwd=%0d hold=%0d early=%0d count=%0d", n_tri, oob, fwd, hold, rdy_early, cull_count);
   endtask

   typedef struct {
      Triangle3D t;
      bit        exp_oob;
      int        hold;
      bit        rdy_early;
   } vec_t;

   initial begin
      vec_t      vecs [8];
      Triangle3D t;
      total     = 0;
      bad       = 0;
      model_cnt = 0;
      n_tri     = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tri_in    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", {in_ready, busy, out_valid}, 3'b100);
      check("rst_tri", tri_out, 96'd0);
      check("rst_cnt", cull_count, 4'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         vecs[i].t         = '0;
         vecs[i].hold      = 0;
         vecs[i].rdy_early = 1'b0;
      end
      vecs[0].exp_oob = 1'b0;                                       // all zero
      vecs[1].t.r.z   = `ZMAX + 16'sd1;          vecs[1].exp_oob = 1'b1;
      vecs[2].t.p.x   = `XMIN;                   vecs[2].exp_oob = 1'b0;
      vecs[3].t       = '{p: '{`XMAX, `YMAX, `ZMAX}, q: '{`XMIN, `YMIN, `ZMIN}, r: '{`XMAX, `YMIN, `ZMAX}};
      vecs[3].exp_oob = 1'b0;  vecs[3].hold = 10;                   // stall downstream 10 cycles
      vecs[4].t.q.y   = `YMIN - 16'sd1;          vecs[4].exp_oob = 1'b1;
      vecs[5].t.p.x   = `XMAX + 16'sd1;          vecs[5].exp_oob = 1'b1;
      vecs[6].t.q.y   = `YMAX + 16'sd50;         vecs[6].exp_oob = 1'b1;
      vecs[7].t.r.x   = -16'sd32768; vecs[7].t.p.z = 16'sd5;         vecs[7].exp_oob = 1'b1;
      vecs[2].rdy_early = 1'b1;

      for (int i = 0; i < 8; i++) begin
         check($sformatf("vec%0d_oob_model", i), model_oob(vecs[i].t), vecs[i].exp_oob);
         run_tri(vecs[i].t, vecs[i].hold, vecs[i].rdy_early);
      end

      // Clamp build: q.y above YMAX must come out exactly at YMAX.
      if (CLAMP) begin
         t = vecs[6].t;
         t.q.y = `YMAX;
         check("clamp_model_qy", model_clamp(vecs[6].t), t);
      end

      for (int i = 0; i < 40; i++) begin
         t.p = rand_pt();
         t.q = rand_pt();
         t.r = rand_pt();
         run_tri(t, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      for (int i = 0; i < (1 << CW) + 3; i++) begin
         t     = '0;
         t.p.x = `XMAX + 16'sd1;
         run_tri(t, 0, 1'b1);
      end
      check("saturated", cull_count, 4'd15);

      // Reset in CHECK cycle 2: triangle lost, counter cleared.
      t     = '0;
      t.q.z = -16'sd1;
      tri_in   = t;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("midrst_ctrl", {in_ready, busy, out_valid}, 3'b100);
      check("midrst_tri", tri_out, 96'd0);
      check("midrst_cnt", cull_count, 4'd0);
      model_cnt = 0;
      @(negedge clk);
      rst = 1'b0;
      tick();
      t     = '0;
      t.p.x = 16'sd100;
      t.r.y = -16'sd7;
      run_tri(t, 2, 1'b0);
      t.r.z = `ZMAX + 16'sd1;
      run_tri(t, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
